// File: rtl/tpu_pkg.sv
// Shared types and constants for the leaky-ReLU-derivative writeback path.
package tpu_pkg;

  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } wb_state_t;

  // Column 1 occupies the low half of the packed row word.
  localparam bit PACK_COL1_LOW = 1'b1;

endpackage

// File: rtl/lr_d_col_fifo.sv
// Per-column synchronous FIFO; a pushed entry becomes poppable one cycle after its push.
module lr_d_col_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [DATA_W-1:0] o_head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wptr;
  logic [AW:0]       r_wptr_vis;
  logic [AW:0]       r_rptr;
  logic              w_push;
  logic              w_pop;

  // Full uses the live write pointer; empty uses the lagged copy, giving the read-side delay.
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_empty = (r_wptr_vis == r_rptr);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (!i_rst || i_clr) begin
      r_wptr     <= '0;
      r_wptr_vis <= '0;
      r_rptr     <= '0;
    end else begin
      r_wptr_vis <= r_wptr;
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/lr_d_writeback.sv
// Deskews two gradient columns, packs rows into 32-bit words and writes them to the
// unified buffer at sequential addresses with valid/ready backpressure.
module lr_d_writeback
  import tpu_pkg::*;
#(
  parameter int unsigned DATA_W = tpu_pkg::DATA_W,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned ROWS_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     lr_d_valid_1_in,
  input  logic                     lr_d_valid_2_in,
  input  logic signed [DATA_W-1:0] lr_d_data_1_in,
  input  logic signed [DATA_W-1:0] lr_d_data_2_in,
  input  logic                     wb_start_in,
  input  logic [ADDR_W-1:0]        wb_base_addr_in,
  input  logic [ROWS_W-1:0]        wb_num_rows_in,
  input  logic                     ub_wr_ready_in,
  output logic                     ub_wr_valid_out,
  output logic [ADDR_W-1:0]        ub_wr_addr_out,
  output logic [2*DATA_W-1:0]      ub_wr_data_out,
  output logic                     wb_busy_out,
  output logic                     wb_done_out,
  output logic                     wb_overflow_out
);

  localparam logic [ROWS_W-1:0] ROWS_ONE = ROWS_W'(1);

  wb_state_t           r_state;
  logic [ADDR_W-1:0]   r_base;
  logic [ROWS_W-1:0]   r_rows;
  logic [ROWS_W-1:0]   r_push_cnt1;
  logic [ROWS_W-1:0]   r_push_cnt2;
  logic [ROWS_W-1:0]   r_issued;
  logic [ROWS_W-1:0]   r_written;
  logic                r_valid;
  logic [ADDR_W-1:0]   r_addr;
  logic [2*DATA_W-1:0] r_data;
  logic                r_overflow;

  logic                w_run;
  logic                w_start;
  logic                w_accept;
  logic                w_last;
  logic                w_full1;
  logic                w_full2;
  logic                w_empty1;
  logic                w_empty2;
  logic [DATA_W-1:0]   w_head1;
  logic [DATA_W-1:0]   w_head2;
  logic                w_push1;
  logic                w_push2;
  logic                w_drop1;
  logic                w_drop2;
  logic                w_pop;
  logic [2*DATA_W-1:0] w_row;

  assign w_run    = (r_state == RUN);
  assign w_start  = (r_state == IDLE) && wb_start_in;
  assign w_accept = r_valid && ub_wr_ready_in;
  assign w_last   = w_accept && (r_written == r_rows - ROWS_ONE);

  // Fullness is sampled before any same-cycle pop, so a full FIFO always drops.
  assign w_push1 = w_run && lr_d_valid_1_in && !w_full1 && (r_push_cnt1 < r_rows);
  assign w_push2 = w_run && lr_d_valid_2_in && !w_full2 && (r_push_cnt2 < r_rows);
  assign w_drop1 = w_run && lr_d_valid_1_in && !w_push1;
  assign w_drop2 = w_run && lr_d_valid_2_in && !w_push2;
  assign w_pop   = w_run && !w_empty1 && !w_empty2 && (!r_valid || w_accept);
  assign w_row   = PACK_COL1_LOW ? {w_head2, w_head1} : {w_head1, w_head2};

  lr_d_col_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo_col1 (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_clr   (w_start),
    .i_push  (w_push1),
    .i_pop   (w_pop),
    .i_data  (lr_d_data_1_in),
    .o_full  (w_full1),
    .o_empty (w_empty1),
    .o_head  (w_head1)
  );

  lr_d_col_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo_col2 (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_clr   (w_start),
    .i_push  (w_push2),
    .i_pop   (w_pop),
    .i_data  (lr_d_data_2_in),
    .o_full  (w_full2),
    .o_empty (w_empty2),
    .o_head  (w_head2)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_rows      <= '0;
      r_push_cnt1 <= '0;
      r_push_cnt2 <= '0;
      r_issued    <= '0;
      r_written   <= '0;
      r_valid     <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_push1) r_push_cnt1 <= r_push_cnt1 + ROWS_ONE;
      if (w_push2) r_push_cnt2 <= r_push_cnt2 + ROWS_ONE;
      if (w_drop1 || w_drop2) r_overflow <= 1'b1;
      if (w_accept) r_written <= r_written + ROWS_ONE;

      if (w_pop) begin
        r_valid  <= 1'b1;
        r_addr   <= r_base + ADDR_W'(r_issued);
        r_data   <= w_row;
        r_issued <= r_issued + ROWS_ONE;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end

      unique case (r_state)
        IDLE: begin
          if (wb_start_in) begin
            r_base      <= wb_base_addr_in;
            r_rows      <= wb_num_rows_in;
            r_push_cnt1 <= '0;
            r_push_cnt2 <= '0;
            r_issued    <= '0;
            r_written   <= '0;
            r_overflow  <= 1'b0;
            r_state     <= (wb_num_rows_in == '0) ? DONE : RUN;
          end
        end
        RUN:     if (w_last) r_state <= DONE;
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ub_wr_valid_out = r_valid;
  assign ub_wr_addr_out  = r_addr;
  assign ub_wr_data_out  = r_data;
  assign wb_busy_out     = (r_state == RUN);
  assign wb_done_out     = (r_state == DONE);
  assign wb_overflow_out = r_overflow;

endmodule

// File: tb/tb_lr_d_writeback.sv
// Directed bench for lr_d_writeback: skewed input, backpressure, overflow, excess input,
// zero rows, address wrap and mid-transfer reset.
module tb_lr_d_writeback;

  logic               clk = 1'b0;
  logic               rst;
  logic               lr_d_valid_1_in;
  logic               lr_d_valid_2_in;
  logic signed [15:0] lr_d_data_1_in;
  logic signed [15:0] lr_d_data_2_in;
  logic               wb_start_in;
  logic [7:0]         wb_base_addr_in;
  logic [7:0]         wb_num_rows_in;
  logic               ub_wr_ready_in;
  logic               ub_wr_valid_out;
  logic [7:0]         ub_wr_addr_out;
  logic [31:0]        ub_wr_data_out;
  logic               wb_busy_out;
  logic               wb_done_out;
  logic               wb_overflow_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lr_d_writeback dut (
    .clk             (clk),
    .rst             (rst),
    .lr_d_valid_1_in (lr_d_valid_1_in),
    .lr_d_valid_2_in (lr_d_valid_2_in),
    .lr_d_data_1_in  (lr_d_data_1_in),
    .lr_d_data_2_in  (lr_d_data_2_in),
    .wb_start_in     (wb_start_in),
    .wb_base_addr_in (wb_base_addr_in),
    .wb_num_rows_in  (wb_num_rows_in),
    .ub_wr_ready_in  (ub_wr_ready_in),
    .ub_wr_valid_out (ub_wr_valid_out),
    .ub_wr_addr_out  (ub_wr_addr_out),
    .ub_wr_data_out  (ub_wr_data_out),
    .wb_busy_out     (wb_busy_out),
    .wb_done_out     (wb_done_out),
    .wb_overflow_out (wb_overflow_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_xfer(input logic [7:0] base, input logic [7:0] rows);
    wb_start_in     = 1'b1;
    wb_base_addr_in = base;
    wb_num_rows_in  = rows;
    step();
    wb_start_in = 1'b0;
  endtask

  // Waits (bounded) for an accepted write, checks it, then lets the edge consume it.
  task automatic wait_write(input string tag, input logic [7:0] addr, input logic [31:0] data);
    for (int i = 0; i < 20; i++) begin
      if (ub_wr_valid_out && ub_wr_ready_in) break;
      step();
    end
    chk({tag, "_valid"}, 32'(ub_wr_valid_out), 32'd1);
    chk({tag, "_addr"}, 32'(ub_wr_addr_out), 32'(addr));
    chk({tag, "_data"}, ub_wr_data_out, data);
    step();
  endtask

  task automatic set_cols(input logic v1, input logic [15:0] d1, input logic v2,
                          input logic [15:0] d2);
    lr_d_valid_1_in = v1;
    lr_d_data_1_in  = d1;
    lr_d_valid_2_in = v2;
    lr_d_data_2_in  = d2;
  endtask

  initial begin
    rst = 1'b0;
    wb_start_in = 1'b0;
    wb_base_addr_in = '0;
    wb_num_rows_in = '0;
    ub_wr_ready_in = 1'b1;
    set_cols(1'b0, 16'h0, 1'b0, 16'h0);
    step();
    step();
    chk("rst_valid", 32'(ub_wr_valid_out), 32'd0);
    chk("rst_addr", 32'(ub_wr_addr_out), 32'd0);
    chk("rst_data", ub_wr_data_out, 32'd0);
    chk("rst_busy", 32'(wb_busy_out), 32'd0);
    chk("rst_done", 32'(wb_done_out), 32'd0);
    chk("rst_ovf", 32'(wb_overflow_out), 32'd0);
    rst = 1'b1;
    step();

    // 1: basic skewed input, cycle-exact
    start_xfer(8'h10, 8'd3);
    chk("s1_busy", 32'(wb_busy_out), 32'd1);
    set_cols(1'b1, 16'h0100, 1'b0, 16'h0);
    step();
    set_cols(1'b1, 16'h0200, 1'b1, 16'hFF00);
    step();
    chk("s1_lat0", 32'(ub_wr_valid_out), 32'd0);
    set_cols(1'b1, 16'h0300, 1'b1, 16'h0080);
    step();
    chk("s1_lat1", 32'(ub_wr_valid_out), 32'd0);
    set_cols(1'b0, 16'h0, 1'b1, 16'h0040);
    step();
    chk("s1_w0_valid", 32'(ub_wr_valid_out), 32'd1);
    chk("s1_w0_addr", 32'(ub_wr_addr_out), 32'h10);
    chk("s1_w0_data", ub_wr_data_out, 32'hFF000100);
    set_cols(1'b0, 16'h0, 1'b0, 16'h0);
    step();
    chk("s1_w1_addr", 32'(ub_wr_addr_out), 32'h11);
    chk("s1_w1_data", ub_wr_data_out, 32'h00800200);
    step();
    chk("s1_w2_valid", 32'(ub_wr_valid_out), 32'd1);
    chk("s1_w2_addr", 32'(ub_wr_addr_out), 32'h12);
    chk("s1_w2_data", ub_wr_data_out, 32'h00400300);
    chk("s1_done_early", 32'(wb_done_out), 32'd0);
    step();
    chk("s1_done", 32'(wb_done_out), 32'd1);
    chk("s1_valid_end", 32'(ub_wr_valid_out), 32'd0);
    chk("s1_busy_end", 32'(wb_busy_out), 32'd0);
    step();
    chk("s1_done_once", 32'(wb_done_out), 32'd0);
    chk("s1_ovf", 32'(wb_overflow_out), 32'd0);

    // 2: backpressure on the first write, plus an ignored start during RUN
    start_xfer(8'h10, 8'd3);
    set_cols(1'b1, 16'h0100, 1'b0, 16'h0);
    step();
    set_cols(1'b1, 16'h0200, 1'b1, 16'hFF00);
    step();
    set_cols(1'b1, 16'h0300, 1'b1, 16'h0080);
    step();
    set_cols(1'b0, 16'h0, 1'b1, 16'h0040);
    ub_wr_ready_in = 1'b0;
    step();
    chk("s2_h0_valid", 32'(ub_wr_valid_out), 32'd1);
    set_cols(1'b0, 16'h0, 1'b0, 16'h0);
    wb_start_in = 1'b1;
    wb_base_addr_in = 8'h80;
    wb_num_rows_in = 8'd1;
    step();
    wb_start_in = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("s2_h%0d_valid", i), 32'(ub_wr_valid_out), 32'd1);
      chk($sformatf("s2_h%0d_addr", i), 32'(ub_wr_addr_out), 32'h10);
      chk($sformatf("s2_h%0d_data", i), ub_wr_data_out, 32'hFF000100);
      if (i < 3) step();
    end
    ub_wr_ready_in = 1'b1;
    wait_write("s2_w0", 8'h10, 32'hFF000100);
    wait_write("s2_w1", 8'h11, 32'h00800200);
    wait_write("s2_w2", 8'h12, 32'h00400300);
    chk("s2_done", 32'(wb_done_out), 32'd1);
    chk("s2_ovf", 32'(wb_overflow_out), 32'd0);
    step();

    // 3: FIFO overflow with ready held low
    ub_wr_ready_in = 1'b0;
    start_xfer(8'h20, 8'd8);
    for (int c = 0; c <= 6; c++) begin
      set_cols(c < 6, 16'(c + 1), c >= 1, 16'(16'h0100 + c));
      step();
    end
    set_cols(1'b0, 16'h0, 1'b0, 16'h0);
    step();
    chk("s3_ovf", 32'(wb_overflow_out), 32'd1);
    chk("s3_pending", 32'(ub_wr_valid_out), 32'd1);
    ub_wr_ready_in = 1'b1;
    for (int r = 0; r < 5; r++)
      wait_write($sformatf("s3_w%0d", r), 8'(32'h20 + r), 32'h01010001 + 32'h00010001 * r);
    step();
    chk("s3_no_sixth", 32'(ub_wr_valid_out), 32'd0);
    chk("s3_no_done", 32'(wb_done_out), 32'd0);
    chk("s3_still_busy", 32'(wb_busy_out), 32'd1);
    ub_wr_ready_in = 1'b0;
    for (int c = 0; c <= 3; c++) begin
      set_cols(c < 3, 16'(c + 7), c >= 1, 16'(16'h0106 + c));
      step();
    end
    set_cols(1'b0, 16'h0, 1'b0, 16'h0);
    ub_wr_ready_in = 1'b1;
    for (int r = 5; r < 8; r++)
      wait_write($sformatf("s3_t%0d", r), 8'(32'h20 + r), 32'h01010001 + 32'h00010001 * (r + 1));
    chk("s3_done", 32'(wb_done_out), 32'd1);
    chk("s3_ovf_sticky", 32'(wb_overflow_out), 32'd1);
    step();

    // 4: excess input beyond the row count
    start_xfer(8'h40, 8'd2);
    chk("s4_ovf_cleared", 32'(wb_overflow_out), 32'd0);
    set_cols(1'b1, 16'h1111, 1'b0, 16'h0);
    step();
    set_cols(1'b1, 16'h2222, 1'b1, 16'hAAAA);
    step();
    set_cols(1'b1, 16'h3333, 1'b1, 16'hBBBB);
    step();
    set_cols(1'b0, 16'h0, 1'b1, 16'hCCCC);
    step();
    chk("s4_w0_addr", 32'(ub_wr_addr_out), 32'h40);
    chk("s4_w0_data", ub_wr_data_out, 32'hAAAA1111);
    chk("s4_ovf", 32'(wb_overflow_out), 32'd1);
    set_cols(1'b0, 16'h0, 1'b0, 16'h0);
    step();
    chk("s4_w1_addr", 32'(ub_wr_addr_out), 32'h41);
    chk("s4_w1_data", ub_wr_data_out, 32'hBBBB2222);
    step();
    chk("s4_done", 32'(wb_done_out), 32'd1);
    chk("s4_valid_end", 32'(ub_wr_valid_out), 32'd0);
    step();
    chk("s4_no_third", 32'(ub_wr_valid_out), 32'd0);

    // 5A: zero rows
    start_xfer(8'h30, 8'd0);
    chk("s5a_done", 32'(wb_done_out), 32'd1);
    chk("s5a_busy", 32'(wb_busy_out), 32'd0);
    chk("s5a_valid", 32'(ub_wr_valid_out), 32'd0);
    chk("s5a_ovf", 32'(wb_overflow_out), 32'd0);
    step();
    chk("s5a_done_once", 32'(wb_done_out), 32'd0);

    // 5B: address wrap
    start_xfer(8'hFF, 8'd2);
    for (int c = 0; c <= 2; c++) begin
      set_cols(c < 2, 16'(16'h0A00 + c), c >= 1, 16'(16'h0AFF + c));
      step();
    end
    set_cols(1'b0, 16'h0, 1'b0, 16'h0);
    wait_write("s5b_w0", 8'hFF, 32'h0B000A00);
    wait_write("s5b_w1", 8'h00, 32'h0B010A01);
    chk("s5b_done", 32'(wb_done_out), 32'd1);
    step();

    // 6: reset after the first write
    start_xfer(8'h10, 8'd3);
    set_cols(1'b1, 16'h0100, 1'b0, 16'h0);
    step();
    set_cols(1'b1, 16'h0200, 1'b1, 16'hFF00);
    step();
    set_cols(1'b1, 16'h0300, 1'b1, 16'h0080);
    step();
    set_cols(1'b0, 16'h0, 1'b1, 16'h0040);
    step();
    set_cols(1'b0, 16'h0, 1'b0, 16'h0);
    step();
    chk("s6_pre_addr", 32'(ub_wr_addr_out), 32'h11);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("s6_valid", 32'(ub_wr_valid_out), 32'd0);
    chk("s6_addr", 32'(ub_wr_addr_out), 32'd0);
    chk("s6_data", ub_wr_data_out, 32'd0);
    chk("s6_busy", 32'(wb_busy_out), 32'd0);
    chk("s6_done", 32'(wb_done_out), 32'd0);
    chk("s6_ovf", 32'(wb_overflow_out), 32'd0);
    set_cols(1'b1, 16'h5555, 1'b1, 16'h6666);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("s6_ign%0d_valid", i), 32'(ub_wr_valid_out), 32'd0);
      chk($sformatf("s6_ign%0d_busy", i), 32'(wb_busy_out), 32'd0);
      chk($sformatf("s6_ign%0d_ovf", i), 32'(wb_overflow_out), 32'd0);
    end
    set_cols(1'b0, 16'h0, 1'b0, 16'h0);
    start_xfer(8'h50, 8'd1);
    set_cols(1'b1, 16'h1234, 1'b0, 16'h0);
    step();
    set_cols(1'b0, 16'h0, 1'b1, 16'h5678);
    step();
    set_cols(1'b0, 16'h0, 1'b0, 16'h0);
    wait_write("s6_new", 8'h50, 32'h56781234);
    chk("s6_new_done", 32'(wb_done_out), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
